fifo_write_arbiter: RTL

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_arb_pkg.sv | 45 ++++
 rtl/fifo_write_arbiter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-requester FIFO write arbiter: FSM states,
// grant encodings, priority-pointer values, the burst default and the
// grant-selection rule used both from IDLE and on release.
package fifo_arb_pkg;

    // State encoding matches the one-hot {B,A} grant so GNT is a direct decode.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } arbState_e;

    localparam logic [1:0] GNT_IDLE = 2'b00;
    localparam logic [1:0] GNT_A    = 2'b01;
    localparam logic [1:0] GNT_B    = 2'b10;

    // Priority pointer values: which requester wins when both ask at once.
    localparam logic PRI_A = 1'b0;
    localparam logic PRI_B = 1'b1;

    localparam int BURST_DEFAULT = 4;

    // Grant choice for a free arbiter: nothing while the FIFO is full, a sole
    // requester wins outright, a tie goes to the requester named by pri.
    function automatic arbState_e selectGrant(
        input logic reqA,
        input logic reqB,
        input logic fifoFull,
        input logic pri
    );
        arbState_e nextState;
        nextState = IDLE;
        if (!fifoFull) begin
            if (reqA && reqB) begin
                nextState = (pri == PRI_B) ? GRANT_B : GRANT_A;
            end else if (reqA) begin
                nextState = GRANT_A;
            end else if (reqB) begin
                nextState = GRANT_B;
            end
        end
        return nextState;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter.sv
// Two-requester write arbiter in front of a FIFO. A granted requester may
// write up to BURST words; the grant then passes to the other requester if it
// is waiting, so both requesters alternate without idle cycles. The block
// holds no data: DIN is a mux of the requester inputs and WE/ACK are
// combinational from the registered grant.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int BURST = BURST_DEFAULT,
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ_A,
    input  logic [WIDTH-1:0] DIN_A,
    output logic             ACK_A,
    input  logic             REQ_B,
    input  logic [WIDTH-1:0] DIN_B,
    output logic             ACK_B,
    input  logic             FF,
    output logic             WE,
    output logic [WIDTH-1:0] DIN,
    output logic [1:0]       GNT,
    output logic             BUSY
);

    // Count value at which the next accepted word completes the burst.
    localparam logic [3:0] LAST_COUNT = 4'(BURST - 1);

    arbState_e  stateReg;
    logic [3:0] countReg;
    logic       priReg;

    logic       grantedReq;   // request line of the current grant holder
    logic       otherPri;     // pointer value naming the non-served requester

    // Request line and "the other one" for whichever requester holds the grant.
    always_comb begin
        grantedReq = 1'b0;
        otherPri   = priReg;
        case (stateReg)
            GRANT_A: begin
                grantedReq = REQ_A;
                otherPri   = PRI_B;
            end
            GRANT_B: begin
                grantedReq = REQ_B;
                otherPri   = PRI_A;
            end
            default: begin
                grantedReq = 1'b0;
                otherPri   = priReg;
            end
        endcase
    end

    // Arbiter FSM: grant selection, burst counting, stall on full, release
    // with priority hand-over.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stateReg <= IDLE;
            countReg <= '0;
            priReg   <= PRI_A;
        end else begin
            case (stateReg)
                IDLE: begin
                    stateReg <= selectGrant(REQ_A, REQ_B, FF, priReg);
                    countReg <= '0;
                end
                GRANT_A, GRANT_B: begin
                    if (!grantedReq) begin
                        // Requester withdrew: release. The pointer only moves
                        // if this grant actually wrote something.
                        countReg <= '0;
                        if (countReg != 4'd0) begin
                            priReg   <= otherPri;
                            stateReg <= selectGrant(REQ_A, REQ_B, FF, otherPri);
                        end else begin
                            stateReg <= selectGrant(REQ_A, REQ_B, FF, priReg);
                        end
                    end else if (!FF) begin
                        // A word is written this cycle.
                        if (countReg == LAST_COUNT) begin
                            countReg <= '0;
                            priReg   <= otherPri;
                            stateReg <= selectGrant(REQ_A, REQ_B, FF, otherPri);
                        end else begin
                            countReg <= countReg + 4'd1;
                        end
                    end
                    // FIFO full with request held: stall, keep grant and count.
                end
                default: begin
                    stateReg <= IDLE;
                    countReg <= '0;
                end
            endcase
        end
    end

    // Write path: the grant holder's word goes through whenever the FIFO has room.
    always_comb begin
        WE    = 1'b0;
        ACK_A = 1'b0;
        ACK_B = 1'b0;
        DIN   = DIN_A;
        case (stateReg)
            GRANT_A: begin
                ACK_A = REQ_A & ~FF;
                WE    = REQ_A & ~FF;
                DIN   = DIN_A;
            end
            GRANT_B: begin
                ACK_B = REQ_B & ~FF;
                WE    = REQ_B & ~FF;
                DIN   = DIN_B;
            end
            default: begin
                WE    = 1'b0;
                ACK_A = 1'b0;
                ACK_B = 1'b0;
                DIN   = DIN_A;
            end
        endcase
    end

    // Grant status decoded straight from the state register.
    always_comb begin
        GNT = GNT_IDLE;
        case (stateReg)
            GRANT_A: GNT = GNT_A;
            GRANT_B: GNT = GNT_B;
            default: GNT = GNT_IDLE;
        endcase
        BUSY = (stateReg != IDLE);
    end

endmodule
